// File: rtl/lane_deskew_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lane_deskew_pkg
// Description : Shared constants, pointer-width helper and aligned-pair type
//               for the dual-lane deskew buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package lane_deskew_pkg;

    localparam int c_DEF_WIDTH = 3;
    localparam int c_DEF_DEPTH = 8;

    // Pointer carries one extra wrap bit above the memory index.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic [c_DEF_WIDTH-1:0] lane0;
        logic [c_DEF_WIDTH-1:0] lane1;
    } pair_t;

endpackage
`default_nettype wire

// File: rtl/lane_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lane_fifo
// Description : Single-lane circular buffer with wrap-bit pointers. Accepts a
//               push on a full buffer only when a pop frees the head slot on
//               the same edge; otherwise the word is dropped and flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_fifo
    import lane_deskew_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int DEPTH = c_DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      push,
    input  logic [WIDTH-1:0]          data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head,
    output logic                      empty,
    output logic                      full,
    output logic [ptr_w(DEPTH)-1:0]   level,
    output logic                      drop
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_pop;
    logic w_accept;

    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                      (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign level    = r_wr_ptr - r_rd_ptr;
    assign head     = r_mem[r_rd_ptr[AW-1:0]];
    assign w_pop    = pop && !empty;
    assign w_accept = push && (!full || w_pop);
    // A flush discards the word silently, so it never counts as a drop.
    assign drop     = push && full && !w_pop && !flush;

    // Pointer update; flush overrides any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; on full+pop the slot being read out is reused.
    always_ff @(posedge clk) begin
        if (w_accept && !flush) r_mem[r_wr_ptr[AW-1:0]] <= data;
    end

endmodule
`default_nettype wire

// File: rtl/lane_deskew.sv
`default_nettype none
// ============================================================================
// Module      : lane_deskew
// Description : Re-pairs two independently delayed lanes into aligned
//               {lane0, lane1} words on a single valid/ready output.
//               Optional skew monitor enabled by LANE_DESKEW_SKEW_MON_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_deskew
    import lane_deskew_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int DEPTH = c_DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in0_valid,
    input  logic [WIDTH-1:0]         in0_data,
    input  logic                     in1_valid,
    input  logic [WIDTH-1:0]         in1_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out0,
    output logic [WIDTH-1:0]         out1,
    output logic                     overflow,
    output logic [ptr_w(DEPTH)-1:0]  lvl0,
    output logic [ptr_w(DEPTH)-1:0]  lvl1
`ifdef LANE_DESKEW_SKEW_MON_EN
    ,
    output logic [ptr_w(DEPTH)-1:0]  max_skew
`endif
);

    localparam int PW = ptr_w(DEPTH);

    logic w_empty0, w_empty1;
    logic w_full0, w_full1;
    logic w_drop0, w_drop1;
    logic w_pop;
    logic r_overflow;

    // Both lanes pop together so pairs stay aligned.
    assign out_valid = !w_empty0 && !w_empty1;
    assign w_pop     = out_valid && out_ready;
    assign overflow  = r_overflow;

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (in0_valid),
        .data  (in0_data),
        .pop   (w_pop),
        .head  (out0),
        .empty (w_empty0),
        .full  (w_full0),
        .level (lvl0),
        .drop  (w_drop0)
    );

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (in1_valid),
        .data  (in1_data),
        .pop   (w_pop),
        .head  (out1),
        .empty (w_empty1),
        .full  (w_full1),
        .level (lvl1),
        .drop  (w_drop1)
    );

    // Sticky drop flag, cleared only by reset or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_overflow <= 1'b0;
        else if (flush)            r_overflow <= 1'b0;
        else if (w_drop0 || w_drop1) r_overflow <= 1'b1;
    end

`ifdef LANE_DESKEW_SKEW_MON_EN
    logic [PW-1:0] r_max_skew;
    logic [PW-1:0] w_skew;

    assign w_skew   = (lvl0 > lvl1) ? (lvl0 - lvl1) : (lvl1 - lvl0);
    assign max_skew = r_max_skew;

    // Running maximum of the occupancy difference between lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_max_skew <= '0;
        else if (flush)              r_max_skew <= '0;
        else if (w_skew > r_max_skew) r_max_skew <= w_skew;
    end
`endif

endmodule
`default_nettype wire
